// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and sizing helpers for the sequential ALU.
package alu_pkg;

  localparam int unsigned SEL_W   = 5;
  localparam int unsigned STATE_W = 2;

  localparam logic [SEL_W-1:0] OP_ADD  = 5'h00;
  localparam logic [SEL_W-1:0] OP_SUB  = 5'h01;
  localparam logic [SEL_W-1:0] OP_MUL  = 5'h02;
  localparam logic [SEL_W-1:0] OP_DIV  = 5'h03;
  localparam logic [SEL_W-1:0] OP_SHL  = 5'h04;
  localparam logic [SEL_W-1:0] OP_SHR  = 5'h05;
  localparam logic [SEL_W-1:0] OP_ROL  = 5'h06;
  localparam logic [SEL_W-1:0] OP_ROR  = 5'h07;
  localparam logic [SEL_W-1:0] OP_AND  = 5'h08;
  localparam logic [SEL_W-1:0] OP_OR   = 5'h09;
  localparam logic [SEL_W-1:0] OP_NOT  = 5'h0A;
  localparam logic [SEL_W-1:0] OP_XOR  = 5'h0B;
  localparam logic [SEL_W-1:0] OP_NAND = 5'h0C;
  localparam logic [SEL_W-1:0] OP_NOR  = 5'h0D;
  localparam logic [SEL_W-1:0] OP_XNOR = 5'h0E;
  localparam logic [SEL_W-1:0] OP_GT   = 5'h0F;
  localparam logic [SEL_W-1:0] OP_LT   = 5'h10;
  localparam logic [SEL_W-1:0] OP_EQ   = 5'h11;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_BUSY = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand-side and result-side valid/ready bundle of the sequential ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, zero, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, result_hi, carry, zero, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one {hi,lo} shift register.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             div_q, div_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_trial_c;
  logic             div_ge_c;

  // Next-state: load on start, then WIDTH iterations; done flags the final one.
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opb_d  = opb_q;
    div_d  = div_q;
    done_d = done_q;

    // MUL: hi accumulates b when the multiplier LSB is set, then {hi,lo} shifts right.
    mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // DIV: remainder shifts left pulling in the next dividend bit; subtract if it fits.
    div_trial_c = {hi_q, lo_q[WIDTH-1]};
    div_ge_c    = (div_trial_c >= {1'b0, opb_q});

    if (start_i) begin
      cnt_d  = CNT_W'(WIDTH);
      hi_d   = '0;
      lo_d   = a_i;
      opb_d  = b_i;
      div_d  = is_div_i;
      done_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        hi_d = div_ge_c ? WIDTH'(div_trial_c - {1'b0, opb_q}) : div_trial_c[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], div_ge_c};
      end else begin
        hi_d = mul_sum_c[WIDTH:1];
        lo_d = {mul_sum_c[0], lo_q[WIDTH-1:1]};
      end
      if (cnt_q == CNT_W'(1)) begin
        done_d = 1'b1;
      end
    end
  end

  // Iteration registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
      div_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opb_q  <= opb_d;
      div_q  <= div_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign lo_o   = lo_q;
  assign hi_o   = hi_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: FSM, single-cycle datapath and registered result/flag outputs.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               is_div_q, is_div_d;

  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic [WIDTH-1:0]   alu_hi_c;
  logic               alu_carry_c;
  logic               alu_dbz_c;
  logic               long_op_c;
  logic               start_c;

  logic               md_done;
  logic [WIDTH-1:0]   md_lo;
  logic [WIDTH-1:0]   md_hi;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_c),
    .is_div_i(bus.sel == OP_DIV),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  // Single-cycle datapath; also covers DIV by zero, which never iterates.
  always_comb begin
    sum_c       = {1'b0, bus.a} + {1'b0, bus.b};
    alu_res_c   = '1;
    alu_hi_c    = '0;
    alu_carry_c = 1'b0;
    alu_dbz_c   = 1'b0;
    long_op_c   = (bus.sel == OP_MUL) || ((bus.sel == OP_DIV) && (bus.b != '0));
    case (bus.sel)
      OP_ADD:  begin alu_res_c = sum_c[WIDTH-1:0]; alu_carry_c = sum_c[WIDTH]; end
      OP_SUB:  begin alu_res_c = bus.a - bus.b; alu_carry_c = (bus.a < bus.b); end
      OP_MUL:  alu_res_c = '0;
      OP_DIV:  begin alu_res_c = '1; alu_hi_c = bus.a; alu_dbz_c = 1'b1; end
      OP_SHL:  begin alu_res_c = {bus.a[WIDTH-2:0], 1'b0}; alu_carry_c = bus.a[WIDTH-1]; end
      OP_SHR:  begin alu_res_c = {1'b0, bus.a[WIDTH-1:1]}; alu_carry_c = bus.a[0]; end
      OP_ROL:  alu_res_c = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
      OP_ROR:  alu_res_c = {bus.a[0], bus.a[WIDTH-1:1]};
      OP_AND:  alu_res_c = bus.a & bus.b;
      OP_OR:   alu_res_c = bus.a | bus.b;
      OP_NOT:  alu_res_c = ~bus.a;
      OP_XOR:  alu_res_c = bus.a ^ bus.b;
      OP_NAND: alu_res_c = ~(bus.a & bus.b);
      OP_NOR:  alu_res_c = ~(bus.a | bus.b);
      OP_XNOR: alu_res_c = ~(bus.a ^ bus.b);
      OP_GT:   alu_res_c = WIDTH'(bus.a > bus.b);
      OP_LT:   alu_res_c = WIDTH'(bus.a < bus.b);
      OP_EQ:   alu_res_c = WIDTH'(bus.a == bus.b);
      default: alu_res_c = '1;
    endcase
  end

  // FSM next-state and output-register next values.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    is_div_d = is_div_q;
    start_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          if (long_op_c) begin
            start_c  = 1'b1;
            is_div_d = (bus.sel == OP_DIV);
            state_d  = S_BUSY;
          end else begin
            res_d   = alu_res_c;
            hi_d    = alu_hi_c;
            carry_d = alu_carry_c;
            zero_d  = (alu_res_c == '0);
            dbz_d   = alu_dbz_c;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (md_done) begin
          res_d   = md_lo;
          hi_d    = md_hi;
          carry_d = !is_div_q && (|md_hi);
          zero_d  = (md_lo == '0);
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
  end

  // State and output registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      res_q       <= '0;
      hi_q        <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      is_div_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      hi_q        <= hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      is_div_q    <= is_div_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = res_q;
  assign bus.result_hi   = hi_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        c;
    logic        z;
    logic        dz;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld, rdy, use16;
  logic [15:0] opa, opb;
  logic [4:0]  opsel;

  logic        o_valid, o_ready, o_c, o_z, o_dz;
  logic [15:0] o_res, o_hi;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus8();
  alu_seq_if #(.WIDTH(16)) bus16();

  assign bus8.in_valid   = vld & ~use16;
  assign bus8.a          = opa[7:0];
  assign bus8.b          = opb[7:0];
  assign bus8.sel        = opsel;
  assign bus8.out_ready  = rdy & ~use16;
  assign bus16.in_valid  = vld & use16;
  assign bus16.a         = opa;
  assign bus16.b         = opb;
  assign bus16.sel       = opsel;
  assign bus16.out_ready = rdy & use16;

  alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  alu_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  always_comb begin
    if (use16) begin
      o_valid = bus16.out_valid; o_ready = bus16.in_ready;
      o_res = bus16.result; o_hi = bus16.result_hi;
      o_c = bus16.carry; o_z = bus16.zero; o_dz = bus16.div_by_zero;
    end else begin
      o_valid = bus8.out_valid; o_ready = bus8.in_ready;
      o_res = {8'd0, bus8.result}; o_hi = {8'd0, bus8.result_hi};
      o_c = bus8.carry; o_z = bus8.zero; o_dz = bus8.div_by_zero;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour built from plain arithmetic on wide integers.
  function automatic exp_t model(input int unsigned w, input logic [15:0] a_in,
                                 input logic [15:0] b_in, input logic [4:0] s);
    exp_t e;
    logic [31:0] m, aa, bb, r, h, t;
    m = (32'd1 << w) - 32'd1;
    aa = {16'd0, a_in} & m;
    bb = {16'd0, b_in} & m;
    r = 0; h = 0; e.c = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (s)
      5'h00: begin t = aa + bb; r = t & m; e.c = t[w]; end
      5'h01: begin r = (aa - bb) & m; e.c = (aa < bb); end
      5'h02: begin t = aa * bb; r = t & m; h = (t >> w) & m; e.c = (h != 0); e.lat = w + 1; end
      5'h03: begin
        if (bb == 0) begin r = m; h = aa; e.dz = 1'b1; end
        else begin r = aa / bb; h = aa % bb; e.lat = w + 1; end
      end
      5'h04: begin r = (aa << 1) & m; e.c = aa[w-1]; end
      5'h05: begin r = aa >> 1; e.c = aa[0]; end
      5'h06: r = ((aa << 1) | (aa >> (w - 1))) & m;
      5'h07: r = (aa >> 1) | ((aa & 32'd1) << (w - 1));
      5'h08: r = aa & bb;
      5'h09: r = aa | bb;
      5'h0A: r = ~aa & m;
      5'h0B: r = aa ^ bb;
      5'h0C: r = ~(aa & bb) & m;
      5'h0D: r = ~(aa | bb) & m;
      5'h0E: r = ~(aa ^ bb) & m;
      5'h0F: r = {31'd0, aa > bb};
      5'h10: r = {31'd0, aa < bb};
      5'h11: r = {31'd0, aa == bb};
      default: r = m;
    endcase
    e.res = r[15:0];
    e.hi  = h[15:0];
    e.z   = (r == 0);
    return e;
  endfunction

  // Drive one op, push its expectation, return #1 after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [4:0] s);
    int guard = 0;
    @(negedge clk);
    while (!o_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", {31'd0, o_ready}, 32'd1);
    opa = a; opb = b; opsel = s; vld = 1'b1;
    exp_q.push_back(model(use16 ? 16 : 8, a, b, s));
    @(posedge clk);
    #1;
    vld = 1'b0;
    opa = 16'($urandom); opb = 16'($urandom); opsel = 5'($urandom);
  endtask

  // Wait for the result, compare with the scoreboard, optionally stall in DONE.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int lat = 0;
    int busy_rdy = 0;
    logic [15:0] snap;
    check({tag, "_sb"}, exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!o_valid && o_ready) busy_rdy++;
    end while (!o_valid && lat < 200);
    check({tag, "_lat"}, lat, e.lat);
    if (e.lat > 1) check({tag, "_busy_rdy"}, busy_rdy, 0);
    check({tag, "_res"}, {16'd0, o_res}, {16'd0, e.res});
    check({tag, "_hi"},  {16'd0, o_hi},  {16'd0, e.hi});
    check({tag, "_c"},   {31'd0, o_c},   {31'd0, e.c});
    check({tag, "_z"},   {31'd0, o_z},   {31'd0, e.z});
    check({tag, "_dz"},  {31'd0, o_dz},  {31'd0, e.dz});
    if (hold > 0) begin
      snap = o_res;
      opa = 16'h00C3; opb = 16'h0011; opsel = OP_ADD; vld = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        check({tag, "_hold_v"},   {31'd0, o_valid}, 32'd1);
        check({tag, "_hold_rdy"}, {31'd0, o_ready}, 32'd0);
        check({tag, "_hold_res"}, {16'd0, o_res},   {16'd0, snap});
      end
      vld = 1'b0;
    end
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    check({tag, "_post_v"},   {31'd0, o_valid}, 32'd0);
    check({tag, "_post_rdy"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; rdy = 1'b0; use16 = 1'b0;
    opa = '0; opb = '0; opsel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_res",   {16'd0, o_res},   32'd0);
    check("rst_hi",    {16'd0, o_hi},    32'd0);
    check("rst_flags", {29'd0, o_c, o_z, o_dz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {31'd0, o_ready}, 32'd1);

    issue(16'h00F0, 16'h0020, OP_ADD); collect("add", 0);
    issue(16'h0005, 16'h0007, OP_SUB); collect("sub", 0);
    issue(16'h0033, 16'h0033, OP_EQ);  collect("eq", 0);
    issue(16'h0012, 16'h0034, 5'h1F);  collect("ill", 0);
    issue(16'h00FF, 16'h00FF, OP_MUL); collect("mul_ff", 0);
    issue(16'd200,  16'd7,    OP_DIV); collect("div", 0);
    issue(16'h0055, 16'h0000, OP_DIV); collect("div0", 0);
    issue(16'h00FF, 16'h0001, OP_ADD); collect("add_wrap", 0);
    issue(16'h0080, 16'h0000, OP_SHL); collect("shl", 0);
    issue(16'h0001, 16'h0000, OP_SHR); collect("shr", 0);
    issue(16'h0081, 16'h0000, OP_ROL); collect("rol", 0);
    issue(16'h0001, 16'h0000, OP_ROR); collect("ror", 0);
    issue(16'h0012, 16'h0034, OP_XOR); collect("stall", 5);
    issue(16'h0040, 16'h0002, OP_SUB); collect("after_stall", 0);

    for (int s = 0; s < 20; s++) begin
      issue(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 5'(s));
      collect("sweep", 0);
    end

    // Abort a multiply in flight with reset.
    issue(16'h00FF, 16'h00FF, OP_MUL);
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_v", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_valid", {31'd0, o_valid}, 32'd0);
    check("abort_res",   {16'd0, o_res},   32'd0);
    check("abort_hi",    {16'd0, o_hi},    32'd0);
    check("abort_flags", {29'd0, o_c, o_z, o_dz}, 32'd0);
    check("abort_ready", {31'd0, o_ready}, 32'd1);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0007, 16'h0008, OP_ADD); collect("add_after_rst", 0);

    // Wide instance: multiply/divide against the reference.
    use16 = 1'b1;
    issue(16'hFFFF, 16'hFFFF, OP_MUL); collect("w16_mul_max", 0);
    issue(16'hFFFF, 16'h0001, OP_DIV); collect("w16_div1", 0);
    issue(16'hFFFF, 16'hFFFF, OP_DIV); collect("w16_div_eq", 0);
    issue(16'h1234, 16'h0000, OP_DIV); collect("w16_div0", 0);
    for (int i = 0; i < 6; i++) begin
      issue(16'($urandom), 16'($urandom), OP_MUL); collect("w16_mul", 0);
      issue(16'($urandom), 16'($urandom_range(1, 300)), OP_DIV); collect("w16_div", 0);
    end
    issue(16'hFFF0, 16'h0020, OP_ADD); collect("w16_add", 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
